// File: rtl/uart_alu_frame_top.sv
// UART-to-ALU bridge: framed little-endian multi-byte requests in, result bytes plus a status byte out.
// Holds the 16x baud tick generator, 8N1 receiver/transmitter, the ALU and the frame sequencer.

module baud_rate_generator #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_tick
);
   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset)                     cnt <= '0;
      else if (cnt == CW'(DIV - 1))    cnt <= '0;
      else                             cnt <= cnt + CW'(1);
   end

   assign o_tick = (cnt == CW'(DIV - 1));
endmodule

module rx (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tick,
   input  logic       i_rx,
   output logic       o_valid,
   output logic [7:0] o_data
);
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t  state, state_next;
   logic [3:0] tcnt, tcnt_next;
   logic [2:0] bcnt, bcnt_next;
   logic [7:0] shreg, shreg_next;
   logic       rx_meta, rx_sync;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         state   <= RX_IDLE;
         tcnt    <= '0;
         bcnt    <= '0;
         shreg   <= '0;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         state   <= state_next;
         tcnt    <= tcnt_next;
         bcnt    <= bcnt_next;
         shreg   <= shreg_next;
      end
   end

   // The start bit is re-checked at its midpoint; every later sample lands 16 ticks apart.
   always_comb begin
      state_next = state;
      tcnt_next  = tcnt;
      bcnt_next  = bcnt;
      shreg_next = shreg;
      case (state)
         RX_IDLE: begin
            if (!rx_sync) begin
               state_next = RX_START;
               tcnt_next  = '0;
            end
         end
         RX_START: begin
            if (i_tick) begin
               if (tcnt == 4'd7) begin
                  tcnt_next  = '0;
                  bcnt_next  = '0;
                  state_next = rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  tcnt_next = tcnt + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (i_tick) begin
               if (tcnt == 4'd15) begin
                  tcnt_next  = '0;
                  shreg_next = {rx_sync, shreg[7:1]};
                  if (bcnt == 3'd7) state_next = RX_STOP;
                  else              bcnt_next  = bcnt + 3'd1;
               end else begin
                  tcnt_next = tcnt + 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (i_tick) begin
               if (tcnt == 4'd15) state_next = RX_IDLE;
               else               tcnt_next  = tcnt + 4'd1;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   always_comb begin
      o_valid = (state == RX_STOP) && i_tick && (tcnt == 4'd15) && rx_sync;
      o_data  = shreg;
   end
endmodule

module tx (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tick,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_serial
);
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t  state, state_next;
   logic [3:0] tcnt, tcnt_next;
   logic [2:0] bcnt, bcnt_next;
   logic [7:0] shreg, shreg_next;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= TX_IDLE;
         tcnt  <= '0;
         bcnt  <= '0;
         shreg <= '0;
      end else begin
         state <= state_next;
         tcnt  <= tcnt_next;
         bcnt  <= bcnt_next;
         shreg <= shreg_next;
      end
   end

   always_comb begin
      state_next = state;
      tcnt_next  = tcnt;
      bcnt_next  = bcnt;
      shreg_next = shreg;
      case (state)
         TX_IDLE: begin
            if (i_valid) begin
               state_next = TX_START;
               tcnt_next  = '0;
               shreg_next = i_data;
            end
         end
         TX_START: begin
            if (i_tick) begin
               if (tcnt == 4'd15) begin
                  state_next = TX_DATA;
                  tcnt_next  = '0;
                  bcnt_next  = '0;
               end else begin
                  tcnt_next = tcnt + 4'd1;
               end
            end
         end
         TX_DATA: begin
            if (i_tick) begin
               if (tcnt == 4'd15) begin
                  tcnt_next  = '0;
                  shreg_next = {1'b0, shreg[7:1]};
                  if (bcnt == 3'd7) state_next = TX_STOP;
                  else              bcnt_next  = bcnt + 3'd1;
               end else begin
                  tcnt_next = tcnt + 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (i_tick) begin
               if (tcnt == 4'd15) state_next = TX_IDLE;
               else               tcnt_next  = tcnt + 4'd1;
            end
         end
         default: state_next = TX_IDLE;
      endcase
   end

   always_comb begin
      case (state)
         TX_START: o_serial = 1'b0;
         TX_DATA:  o_serial = shreg[0];
         default:  o_serial = 1'b1;
      endcase
   end
endmodule

module alu #(
   parameter int NB_DATA = 8,
   parameter int NB_OPS  = 6
) (
   input  logic [NB_DATA-1:0] i_a,
   input  logic [NB_DATA-1:0] i_b,
   input  logic [NB_OPS-1:0]  i_op,
   output logic [NB_DATA-1:0] o_result
);
   localparam logic [NB_OPS-1:0] OP_ADD = NB_OPS'(6'b100000);
   localparam logic [NB_OPS-1:0] OP_SUB = NB_OPS'(6'b100010);
   localparam logic [NB_OPS-1:0] OP_AND = NB_OPS'(6'b100100);
   localparam logic [NB_OPS-1:0] OP_OR  = NB_OPS'(6'b100101);
   localparam logic [NB_OPS-1:0] OP_XOR = NB_OPS'(6'b100110);
   localparam logic [NB_OPS-1:0] OP_NOR = NB_OPS'(6'b100111);
   localparam logic [NB_OPS-1:0] OP_SRA = NB_OPS'(6'b000011);
   localparam logic [NB_OPS-1:0] OP_SRL = NB_OPS'(6'b000010);

   // Unknown opcodes produce zero rather than holding a stale value.
   always_comb begin
      case (i_op)
         OP_ADD:  o_result = i_a + i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_NOR:  o_result = ~(i_a | i_b);
         OP_SRA:  o_result = $signed(i_a) >>> i_b;
         OP_SRL:  o_result = i_a >> i_b;
         default: o_result = '0;
      endcase
   end
endmodule

module uart_alu_frame_top #(
   parameter int         CLK_FREQ      = 100000000,
   parameter int         BAUD_RATE     = 9600,
   parameter int         NB_DATA       = 8,
   parameter int         NB_OPS        = 6,
   parameter logic [7:0] HEADER        = 8'hA5,
   parameter int         TIMEOUT_TICKS = 3200,
   parameter int         TX_GAP_TICKS  = 176
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_rx_data,
   output logic o_tx_serial_data,
   output logic o_busy,
   output logic o_frame_err,
   output logic o_overrun
);
   localparam int NBYTES  = NB_DATA / 8;
   localparam int CNT_MAX = (TIMEOUT_TICKS > TX_GAP_TICKS) ? TIMEOUT_TICKS : TX_GAP_TICKS;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, GET_OP, GET_A, GET_B, EXEC, SEND, SEND_GAP} seq_state_t;

   seq_state_t         state, state_next;
   logic [2:0]         idx, idx_next;
   logic [CW-1:0]      cnt, cnt_next;
   logic [7:0]         op_reg, op_next;
   logic [NB_DATA-1:0] a_reg, a_next, b_reg, b_next, res_reg, res_next;
   logic [7:0]         status_reg, status_next;
   logic               overrun, overrun_next;

   logic               tick, rx_valid, tx_valid, timeout, op_bad;
   logic [7:0]         rx_byte, tx_byte;
   logic [NB_DATA-1:0] alu_result;
   logic [NB_DATA+7:0] reply_word;

   baud_rate_generator #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_baud (
      .i_clk(i_clk), .i_reset(i_reset), .o_tick(tick)
   );

   rx u_rx (
      .i_clk(i_clk), .i_reset(i_reset), .i_tick(tick), .i_rx(i_rx_data),
      .o_valid(rx_valid), .o_data(rx_byte)
   );

   tx u_tx (
      .i_clk(i_clk), .i_reset(i_reset), .i_tick(tick), .i_valid(tx_valid),
      .i_data(tx_byte), .o_serial(o_tx_serial_data)
   );

   alu #(.NB_DATA(NB_DATA), .NB_OPS(NB_OPS)) u_alu (
      .i_a(a_reg), .i_b(b_reg), .i_op(op_reg[NB_OPS-1:0]), .o_result(alu_result)
   );

   // Opcode bits above the ALU's opcode width must be zero for the request to be valid.
   assign op_bad     = (op_reg >> NB_OPS) != 8'h00;
   assign timeout    = ((state == GET_OP) || (state == GET_A) || (state == GET_B)) &&
                       (cnt == CW'(TIMEOUT_TICKS));
   assign reply_word = {status_reg, res_reg};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         op_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         res_reg    <= '0;
         status_reg <= '0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         cnt        <= cnt_next;
         op_reg     <= op_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         res_reg    <= res_next;
         status_reg <= status_next;
         overrun    <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state;
      idx_next     = idx;
      cnt_next     = cnt;
      op_next      = op_reg;
      a_next       = a_reg;
      b_next       = b_reg;
      res_next     = res_reg;
      status_next  = status_reg;
      overrun_next = overrun;
      case (state)
         IDLE: begin
            if (rx_valid && (rx_byte == HEADER)) begin
               state_next   = GET_OP;
               idx_next     = '0;
               cnt_next     = '0;
               overrun_next = 1'b0;
            end
         end
         GET_OP: begin
            if (rx_valid) begin
               op_next    = rx_byte;
               idx_next   = '0;
               cnt_next   = '0;
               state_next = GET_A;
            end else if (tick) begin
               cnt_next = cnt + CW'(1);
            end
         end
         GET_A, GET_B: begin
            if (rx_valid) begin
               cnt_next = '0;
               if (state == GET_A) a_next[8*idx +: 8] = rx_byte;
               else                b_next[8*idx +: 8] = rx_byte;
               if (idx == 3'(NBYTES - 1)) begin
                  idx_next   = '0;
                  state_next = (state == GET_A) ? GET_B : EXEC;
               end else begin
                  idx_next = idx + 3'd1;
               end
            end else if (tick) begin
               cnt_next = cnt + CW'(1);
            end
         end
         EXEC: begin
            res_next     = op_bad ? '0 : alu_result;
            status_next  = op_bad ? 8'h01 : 8'h00;
            idx_next     = '0;
            state_next   = SEND;
            overrun_next = overrun | rx_valid;
         end
         SEND: begin
            cnt_next     = '0;
            state_next   = SEND_GAP;
            overrun_next = overrun | rx_valid;
         end
         SEND_GAP: begin
            overrun_next = overrun | rx_valid;
            if (cnt == CW'(TX_GAP_TICKS)) begin
               if (idx == 3'(NBYTES)) begin
                  idx_next   = '0;
                  state_next = IDLE;
               end else begin
                  idx_next   = idx + 3'd1;
                  state_next = SEND;
               end
            end else if (tick) begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
      // A timeout overrides any byte arriving in the same cycle and drops the partial request.
      if (timeout) begin
         state_next = IDLE;
         idx_next   = '0;
         cnt_next   = '0;
         op_next    = '0;
         a_next     = '0;
         b_next     = '0;
      end
   end

   always_comb begin
      tx_valid    = (state == SEND);
      tx_byte     = reply_word[8*idx +: 8];
      o_busy      = (state != IDLE);
      o_frame_err = timeout;
      o_overrun   = overrun;
   end
endmodule

// File: doc/uart_alu_frame_top.md
Name: uart_alu_frame_top

Overview:
- Next-generation UART-to-ALU system top, a parametrised successor to the current 8-bit single-operand design.
- Instantiates baud_rate_generator, rx, tx and alu. An internal framed-protocol sequencer replaces the simple byte interface.
- ALU width NB_DATA is a multiple of 8. Operands and results are carried as multi-byte little-endian fields.
- Adds header sync, inter-byte timeout, a status byte in every reply and overrun flagging.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz; passed to baud_rate_generator.
- BAUD_RATE, 9600, serial baud rate; passed to baud_rate_generator.
- NB_DATA, 8, ALU operand/result width. Must be a multiple of 8, range 8..32. NBYTES = NB_DATA/8.
- NB_OPS, 6, ALU opcode width (≤8); passed to alu.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_TICKS, 3200, maximum baud ticks allowed between bytes within one frame (20 byte times).
- TX_GAP_TICKS, 176, baud ticks waited after each tx_valid pulse before the next byte is issued.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  1  UART serial input; idle high.
- o_tx_serial_data  out  1  UART serial output; idle high.
- o_busy  out  1  high from header acceptance until the last reply byte's gap expires.
- o_frame_err  out  1  one-cycle pulse when a frame is aborted by timeout.
- o_overrun  out  1  sticky; set when a byte arrives while the sequencer is in EXEC/SEND; cleared on the next accepted header or on reset.

Behaviour:
- Clock/reset: one clock i_clk; reset is synchronous, active-high on i_reset.
- Reset values: state=IDLE, o_busy=0, o_frame_err=0, o_overrun=0, tx_valid=0, operand/op/result registers=0, byte index=0, counters=0. o_tx_serial_data=1 (tx idle).
- Baud tick: the baud_rate_generator tick is 16x baud, so one 8N1 byte takes 160 ticks. Timeout and gap counters advance only on tick.
- Request frame: HEADER, OP, A[7:0] .. A[NB_DATA-1:NB_DATA-8], B bytes in the same order. Total 2+2*NBYTES bytes.
- Reply frame: RES bytes (LS first), then STATUS. Total NBYTES+1 bytes.
- FSM states:
  - IDLE: on rx_valid with data==HEADER go to GET_OP, set o_busy, clear o_overrun and the timeout counter. Any other byte is discarded and the state stays IDLE.
  - GET_OP: on rx_valid store the byte and go to GET_A with index=0.
  - GET_A / GET_B: on rx_valid write the byte into lane [8*idx +: 8] and increment idx. When idx==NBYTES-1, reset idx to 0 and advance (GET_A to GET_B, GET_B to EXEC).
  - EXEC: lasts one cycle. Drive alu with A, B, OP[NB_OPS-1:0] and register the result.
    - If OP[7:NB_OPS] != 0 (only when NB_OPS<8): result=0, status=8'h01.
    - Otherwise: status=8'h00.
  - SEND: pulse tx_valid for one cycle with byte[idx], then wait TX_GAP_TICKS ticks. Repeat for NBYTES result bytes, then the STATUS byte, then return to IDLE and clear o_busy.
- Timeout: in GET_OP/GET_A/GET_B the counter resets on every rx_valid. When it reaches TIMEOUT_TICKS: go to IDLE, pulse o_frame_err, clear o_busy, send no reply, discard partial operands.
- rx_valid in the same cycle as a timeout: the timeout wins; the byte is discarded.
- rx_valid during EXEC/SEND: byte dropped, o_overrun set. It is never interpreted as a new header.
- Latency: first reply tx_valid comes 2 cycles after the last B byte's rx_valid (one cycle to EXEC, one cycle to the first SEND).
- Reset mid-frame or mid-reply: immediate return to IDLE. Any tx byte already started is controlled by tx's own reset.
- HEADER value inside the operand fields is data, not resync.

Test Plan:
- NB_DATA=16: send A5 20 34 12 01 00 (op ADD) -> reply 35 12 00; o_busy high throughout; o_overrun=0.
- NB_DATA=8: send 3C A5 22 0F 05 (leading 3C is junk) -> 3C ignored; reply = alu(0x0F,0x05,0x22) result byte, then 00.
- NB_DATA=16, NB_OPS=6: op byte 0xC0 -> reply 00 00 01.
- NB_DATA=16: send A5 20 34 then stall for > TIMEOUT_TICKS ticks -> one-cycle o_frame_err pulse, no tx activity, IDLE. A following full frame is processed correctly.
- Send a full frame, then inject byte 55 during the reply -> reply unchanged, o_overrun=1. The next A5 clears it.
- Assert i_reset during GET_B -> all outputs at reset values next cycle. A subsequent frame is replied correctly.
